// File: rtl/register_file_if.sv
// Decoder/ROB-facing bundle of the architectural register file.
// Master = decoder + ROB side, slave = register file.
interface register_file_if #(
    parameter int ROB_SIZE_BIT = 4
);
    logic                    rdy_in;
    logic                    clear;

    logic [4:0]              set_reg_id;
    logic [31:0]             set_val;
    logic [ROB_SIZE_BIT-1:0] set_reg_on_rob_id;

    logic [4:0]              set_dep_reg_id;
    logic [ROB_SIZE_BIT-1:0] set_dep_rob_id;

    logic [4:0]              get_reg_id1;
    logic [4:0]              get_reg_id2;

    logic [31:0]             val1;
    logic                    has_dep1;
    logic [ROB_SIZE_BIT-1:0] dep1;
    logic [31:0]             val2;
    logic                    has_dep2;
    logic [ROB_SIZE_BIT-1:0] dep2;

    logic [ROB_SIZE_BIT-1:0] get_rob_id1;
    logic                    rob_value1_ready;
    logic [31:0]             rob_value1;
    logic [ROB_SIZE_BIT-1:0] get_rob_id2;
    logic                    rob_value2_ready;
    logic [31:0]             rob_value2;

    logic [5:0]              pending_cnt;

    modport master (
        output rdy_in, clear,
        output set_reg_id, set_val, set_reg_on_rob_id,
        output set_dep_reg_id, set_dep_rob_id,
        output get_reg_id1, get_reg_id2,
        output rob_value1_ready, rob_value1,
        output rob_value2_ready, rob_value2,
        input  val1, has_dep1, dep1,
        input  val2, has_dep2, dep2,
        input  get_rob_id1, get_rob_id2,
        input  pending_cnt
    );

    modport slave (
        input  rdy_in, clear,
        input  set_reg_id, set_val, set_reg_on_rob_id,
        input  set_dep_reg_id, set_dep_rob_id,
        input  get_reg_id1, get_reg_id2,
        input  rob_value1_ready, rob_value1,
        input  rob_value2_ready, rob_value2,
        output val1, has_dep1, dep1,
        output val2, has_dep2, dep2,
        output get_rob_id1, get_rob_id2,
        output pending_cnt
    );
endinterface

// File: rtl/register_file.sv
// Architectural register file x0..x31 with per-register ROB rename tags.
// Optional REGFILE_ROB_BYPASS_EN: resolve tagged lookups from ROB values.
module register_file #(
    parameter int ROB_SIZE_BIT = 4
) (
    input logic             clk_in,
    input logic             rst_in,
    register_file_if.slave  rf
);

    typedef logic [ROB_SIZE_BIT-1:0] rob_id_t;

    logic [31:0][31:0] value_q, value_d;
    logic [31:0]       busy_q,  busy_d;
    rob_id_t [31:0]    tag_q,   tag_d;
    logic [5:0]        pending_q, pending_d;

    logic commit_v;
    logic disp_v;
    logic commit_hit;
    logic disp_new;
    logic cnt_inc;
    logic cnt_dec;

    assign commit_v = (rf.set_reg_id != 5'd0);
    assign disp_v   = (rf.set_dep_reg_id != 5'd0);

    // Next-state: flush, commit writeback, dispatch rename, pending count
    always_comb begin
        value_d    = value_q;
        busy_d     = busy_q;
        tag_d      = tag_q;
        pending_d  = pending_q;
        commit_hit = 1'b0;
        disp_new   = 1'b0;
        cnt_inc    = 1'b0;
        cnt_dec    = 1'b0;
        if (rf.clear) begin
            busy_d    = '0;
            pending_d = '0;
        end else begin
            if (commit_v) begin
                value_d[rf.set_reg_id] = rf.set_val;
                if (busy_q[rf.set_reg_id] &&
                    tag_q[rf.set_reg_id] == rf.set_reg_on_rob_id) begin
                    busy_d[rf.set_reg_id] = 1'b0;
                    commit_hit = 1'b1;
                end
            end
            if (disp_v) begin
                busy_d[rf.set_dep_reg_id] = 1'b1;
                tag_d[rf.set_dep_reg_id]  = rf.set_dep_rob_id;
                disp_new = !busy_q[rf.set_dep_reg_id];
            end
            // A rename of the committing register keeps it busy
            cnt_inc = disp_new;
            cnt_dec = commit_hit &&
                      !(disp_v && rf.set_dep_reg_id == rf.set_reg_id);
            if (cnt_inc && !cnt_dec)
                pending_d = pending_q + 6'd1;
            else if (cnt_dec && !cnt_inc)
                pending_d = pending_q - 6'd1;
        end
    end

    // State registers; rdy_in low freezes everything
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            value_q   <= '0;
            busy_q    <= '0;
            tag_q     <= '0;
            pending_q <= '0;
        end else if (rf.rdy_in) begin
            value_q   <= value_d;
            busy_q    <= busy_d;
            tag_q     <= tag_d;
            pending_q <= pending_d;
        end
    end

    assign rf.pending_cnt = pending_q;
    assign rf.get_rob_id1 = tag_q[rf.get_reg_id1];
    assign rf.get_rob_id2 = tag_q[rf.get_reg_id2];

    // Operand 1 lookup against pre-edge state
    always_comb begin
        rf.val1     = '0;
        rf.has_dep1 = 1'b0;
        rf.dep1     = '0;
        if (rf.get_reg_id1 == 5'd0) begin
            rf.val1 = '0;
        end else if (!busy_q[rf.get_reg_id1]) begin
            rf.val1 = value_q[rf.get_reg_id1];
`ifdef REGFILE_ROB_BYPASS_EN
        end else if (rf.rob_value1_ready) begin
            rf.val1 = rf.rob_value1;
`endif
        end else begin
            rf.has_dep1 = 1'b1;
            rf.dep1     = tag_q[rf.get_reg_id1];
        end
    end

    // Operand 2 lookup against pre-edge state
    always_comb begin
        rf.val2     = '0;
        rf.has_dep2 = 1'b0;
        rf.dep2     = '0;
        if (rf.get_reg_id2 == 5'd0) begin
            rf.val2 = '0;
        end else if (!busy_q[rf.get_reg_id2]) begin
            rf.val2 = value_q[rf.get_reg_id2];
`ifdef REGFILE_ROB_BYPASS_EN
        end else if (rf.rob_value2_ready) begin
            rf.val2 = rf.rob_value2;
`endif
        end else begin
            rf.has_dep2 = 1'b1;
            rf.dep2     = tag_q[rf.get_reg_id2];
        end
    end

`ifndef REGFILE_ROB_BYPASS_EN
    // Tagged operands resolve later via RS/LSB broadcast
    logic unused_rob;
    assign unused_rob = ^{rf.rob_value1_ready, rf.rob_value1,
                          rf.rob_value2_ready, rf.rob_value2};
`endif

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: lookups push expectations,
// the negedge sampler pops and compares them.
module tb_register_file;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    register_file_if #(.ROB_SIZE_BIT(4)) bus ();

    register_file #(.ROB_SIZE_BIT(4)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .rf     (bus)
    );

    typedef struct {
        string       tag;
        int          what;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.rdy_in            = 1'b1;
        bus.clear             = 1'b0;
        bus.set_reg_id        = 5'd0;
        bus.set_val           = 32'd0;
        bus.set_reg_on_rob_id = 4'd0;
        bus.set_dep_reg_id    = 5'd0;
        bus.set_dep_rob_id    = 4'd0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic commit(input logic [4:0] r, input logic [3:0] id,
                          input logic [31:0] v);
        bus.set_reg_id        = r;
        bus.set_reg_on_rob_id = id;
        bus.set_val           = v;
    endtask

    task automatic disp(input logic [4:0] r, input logic [3:0] id);
        bus.set_dep_reg_id = r;
        bus.set_dep_rob_id = id;
    endtask

    task automatic exp_pend(input string tag, input logic [5:0] v);
        sb.push_back('{{tag, ".pend"}, 0, {26'd0, v}});
    endtask

    // Drive one operand lookup and queue its expected response
    task automatic look(input int op, input logic [4:0] r,
                        input logic rdy, input logic [31:0] rv,
                        input string tag, input logic [31:0] v,
                        input logic hd, input logic [3:0] dep,
                        input logic [3:0] rid);
        int b;
        b = (op == 1) ? 1 : 5;
        if (op == 1) begin
            bus.get_reg_id1      = r;
            bus.rob_value1_ready = rdy;
            bus.rob_value1       = rv;
        end else begin
            bus.get_reg_id2      = r;
            bus.rob_value2_ready = rdy;
            bus.rob_value2       = rv;
        end
        sb.push_back('{{tag, ".val"}, b,     v});
        sb.push_back('{{tag, ".hd"},  b + 1, {31'd0, hd}});
        sb.push_back('{{tag, ".dep"}, b + 2, {28'd0, dep}});
        sb.push_back('{{tag, ".rid"}, b + 3, {28'd0, rid}});
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.what)
                0: obs = {26'd0, bus.pending_cnt};
                1: obs = bus.val1;
                2: obs = {31'd0, bus.has_dep1};
                3: obs = {28'd0, bus.dep1};
                4: obs = {28'd0, bus.get_rob_id1};
                5: obs = bus.val2;
                6: obs = {31'd0, bus.has_dep2};
                7: obs = {28'd0, bus.dep2};
                default: obs = {28'd0, bus.get_rob_id2};
            endcase
            check(e.tag, obs, e.exp);
        end
    endtask

    task automatic sample();
        @(negedge clk);
        drain();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        bus.get_reg_id1 = 5'd0;
        bus.get_reg_id2 = 5'd0;
        bus.rob_value1_ready = 1'b0;
        bus.rob_value1 = 32'd0;
        bus.rob_value2_ready = 1'b0;
        bus.rob_value2 = 32'd0;

        // Power-on reset
        #2 rst = 1'b1;
        #1;
        exp_pend("rst", 6'd0);
        look(1, 5'd5, 1'b0, 32'd0, "rst.x5", 32'd0, 1'b0, 4'd0, 4'd0);
        look(2, 5'd1, 1'b0, 32'd0, "rst.x1", 32'd0, 1'b0, 4'd0, 4'd0);
        drain();
        @(posedge clk);
        #1 rst = 1'b0;

        // Rename x3 -> 7, then look it up
        disp(5'd3, 4'd7);
        cyc();
        look(1, 5'd3, 1'b0, 32'd0, "dep.x3", 32'd0, 1'b1, 4'd7, 4'd7);
        exp_pend("dep", 6'd1);
        sample();

        // ROB value ready while x3 is tagged
`ifdef REGFILE_ROB_BYPASS_EN
        look(1, 5'd3, 1'b1, 32'hDEADBEEF, "byp.x3",
             32'hDEADBEEF, 1'b0, 4'd0, 4'd7);
`else
        look(1, 5'd3, 1'b1, 32'hDEADBEEF, "byp.x3",
             32'd0, 1'b1, 4'd7, 4'd7);
`endif
        look(2, 5'd3, 1'b0, 32'd0, "byp.op2", 32'd0, 1'b1, 4'd7, 4'd7);
        sample();

        // Younger rename survives the older commit
        disp(5'd3, 4'd9);
        cyc();
        look(1, 5'd3, 1'b0, 32'd0, "ren.x3", 32'd0, 1'b1, 4'd9, 4'd9);
        exp_pend("ren", 6'd1);
        sample();
        commit(5'd3, 4'd7, 32'h11);
        cyc();
        look(1, 5'd3, 1'b0, 32'd0, "old.x3", 32'd0, 1'b1, 4'd9, 4'd9);
        exp_pend("old", 6'd1);
        sample();
        commit(5'd3, 4'd9, 32'h22);
        cyc();
        look(1, 5'd3, 1'b0, 32'd0, "new.x3", 32'h22, 1'b0, 4'd0, 4'd9);
        exp_pend("new", 6'd0);
        sample();

        // Same-cycle commit and dispatch of x4
        disp(5'd4, 4'd2);
        cyc();
        commit(5'd4, 4'd2, 32'h44);
        disp(5'd4, 4'd5);
        cyc();
        look(2, 5'd4, 1'b0, 32'd0, "cd.x4", 32'd0, 1'b1, 4'd5, 4'd5);
        exp_pend("cd", 6'd1);
        sample();

        // Own-rd rename not visible to a same-cycle source lookup
        commit(5'd6, 4'd0, 32'h40);
        cyc();
        disp(5'd6, 4'd3);
        look(1, 5'd6, 1'b0, 32'd0, "self.x6", 32'h40, 1'b0, 4'd0, 4'd0);
        sample();
        cyc();
        look(2, 5'd6, 1'b0, 32'd0, "after.x6", 32'd0, 1'b1, 4'd3, 4'd3);
        exp_pend("after", 6'd2);
        sample();

        // Flush with four registers busy
        disp(5'd1, 4'd1);
        cyc();
        disp(5'd2, 4'd4);
        cyc();
        exp_pend("four", 6'd4);
        sample();
        bus.clear = 1'b1;
        commit(5'd1, 4'd1, 32'h99);
        disp(5'd7, 4'd6);
        cyc();
        exp_pend("clr", 6'd0);
        look(1, 5'd1, 1'b0, 32'd0, "clr.x1", 32'd0, 1'b0, 4'd0, 4'd1);
        look(2, 5'd4, 1'b0, 32'd0, "clr.x4", 32'h44, 1'b0, 4'd0, 4'd5);
        sample();
        look(1, 5'd6, 1'b0, 32'd0, "clr.x6", 32'h40, 1'b0, 4'd0, 4'd3);
        look(2, 5'd7, 1'b0, 32'd0, "clr.x7", 32'd0, 1'b0, 4'd0, 4'd0);
        sample();

        // Stall: nothing changes
        bus.rdy_in = 1'b0;
        disp(5'd8, 4'd2);
        commit(5'd9, 4'd0, 32'h77);
        cyc();
        look(1, 5'd8, 1'b0, 32'd0, "stall.x8", 32'd0, 1'b0, 4'd0, 4'd0);
        look(2, 5'd9, 1'b0, 32'd0, "stall.x9", 32'd0, 1'b0, 4'd0, 4'd0);
        exp_pend("stall", 6'd0);
        sample();

        // x0 is never written nor tagged
        disp(5'd0, 4'd5);
        commit(5'd0, 4'd5, 32'h123);
        cyc();
        look(1, 5'd0, 1'b1, 32'hAAAA, "x0", 32'd0, 1'b0, 4'd0, 4'd0);
        exp_pend("x0", 6'd0);
        sample();

        // Highest tag value, op2 ROB path, then commit
        disp(5'd10, 4'd15);
        cyc();
`ifdef REGFILE_ROB_BYPASS_EN
        look(2, 5'd10, 1'b1, 32'h5555, "t15.x10",
             32'h5555, 1'b0, 4'd0, 4'd15);
`else
        look(2, 5'd10, 1'b1, 32'h5555, "t15.x10",
             32'd0, 1'b1, 4'd15, 4'd15);
`endif
        sample();
        commit(5'd10, 4'd15, 32'hF0);
        cyc();
        look(2, 5'd10, 1'b0, 32'd0, "c15.x10", 32'hF0, 1'b0, 4'd0, 4'd15);
        exp_pend("c15", 6'd0);
        sample();

        // Asynchronous reset mid-run with x5 busy
        disp(5'd5, 4'd11);
        cyc();
        look(1, 5'd5, 1'b0, 32'd0, "pre.x5", 32'd0, 1'b1, 4'd11, 4'd11);
        exp_pend("pre", 6'd1);
        sample();
        #2 rst = 1'b1;
        #1;
        look(1, 5'd5, 1'b0, 32'd0, "arst.x5", 32'd0, 1'b0, 4'd0, 4'd0);
        look(2, 5'd3, 1'b0, 32'd0, "arst.x3", 32'd0, 1'b0, 4'd0, 4'd0);
        exp_pend("arst", 6'd0);
        drain();
        @(posedge clk);
        #1 rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- Architectural register file with rename tags. It sits between the decoder and the reorder buffer, acting as the receiving end of the reorder buffer's commit and dependency-set interface.
- It holds x0..x31 values and, for each register, the ROB entry that will produce its next value.
- It answers the decoder's two operand lookups, returning either a value or a dependency tag. While a register is tagged, it resolves the lookup against the reorder buffer's value ports.

Parameters:
- ROB_SIZE_BIT, 4 (`ROB_WIDTH_BIT in const.v): width of ROB entry ids.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  reset, asynchronous, active-high
- rdy_in  in  1  pause when low: no state change
- clear  in  1  flush from ROB (mispredict)
- set_reg_id  in  5  commit target register; 0 = no commit
- set_val  in  32  commit value
- set_reg_on_rob_id  in  ROB_SIZE_BIT  ROB id of the committing entry
- set_dep_reg_id  in  5  dispatch rename target; 0 = none
- set_dep_rob_id  in  ROB_SIZE_BIT  ROB id now producing set_dep_reg_id
- get_reg_id1  in  5  decoder operand 1 register
- get_reg_id2  in  5  decoder operand 2 register
- val1  out  32  operand 1 value (valid when has_dep1=0)
- has_dep1  out  1  operand 1 still pending
- dep1  out  ROB_SIZE_BIT  ROB id operand 1 waits on
- val2, has_dep2, dep2  out  32/1/ROB_SIZE_BIT  same for operand 2
- get_rob_id1  out  ROB_SIZE_BIT  tag of get_reg_id1, driven to ROB
- rob_value1_ready  in  1  ROB reports that entry ready (including same-cycle writeback)
- rob_value1  in  32  ROB value for get_rob_id1
- get_rob_id2, rob_value2_ready, rob_value2  out/in/in  same for operand 2
- pending_cnt  out  6  number of registers currently tagged

Behaviour:
- State per register r: value[r] (32b), busy[r] (1b), tag[r] (ROB_SIZE_BIT). pending_cnt is a registered counter.
- Reset (async, rst_in=1):
  - all value=0, busy=0, tag=0.
  - pending_cnt=0.
  - Outputs are combinational from state, so they read 0 / not pending.
- Posedge with rdy_in=0: hold all state.
- Posedge with clear=1 (and rdy_in=1):
  - busy[*]<=0 and pending_cnt<=0.
  - values are retained.
  - commit and dispatch inputs are ignored that cycle.
- Normal posedge, commit (set_reg_id!=0):
  - value[set_reg_id] <= set_val.
  - If busy and tag==set_reg_on_rob_id, busy is cleared.
  - If the tag differs (a younger rename exists), busy is kept.
- Normal posedge, dispatch (set_dep_reg_id!=0): busy<=1, tag<=set_dep_rob_id.
- Same-register commit and dispatch in one cycle: dispatch wins the busy/tag fields; the value is still written.
- pending_cnt update: +1 per busy 0->1 transition, -1 per 1->0 transition; the net change is in {-1,0,+1}. It never exceeds 31.
- x0 rules:
  - writes to x0 are never performed and x0 is never tagged.
  - lookups of x0 always return val=0, has_dep=0.
- Lookup (combinational, zero latency, operand N):
  - get_rob_idN = tag[get_reg_idN].
  - if !busy: val=value, has_dep=0, dep=0.
  - if busy and rob_valueN_ready: val=rob_valueN, has_dep=0 (bypass).
  - else: val=0, has_dep=1, dep=tag.
  - Lookups see state before this cycle's edge: a same-cycle dispatch to the looked-up register does not affect the result (an instruction's own rd rename is not visible to its sources).
  - A same-cycle commit is covered by the ROB ready bypass, not by set_val.
- ROB id wrap-around: tags are compared for equality only; there is no ordering arithmetic.

Optional Feature:
- REGFILE_ROB_BYPASS_EN
  - defined: busy lookups use rob_valueN_ready/rob_valueN as above.
  - undefined: busy lookups always return has_dep=1, dep=tag, with rob_value inputs ignored. The operand resolves later via RS/LSB broadcast; get_rob_idN is still driven.

Test Plan:
- Reset: assert rst_in mid-run with busy x5 -> immediately pending_cnt=0; lookup x5 gives has_dep=0, val=0.
- Dispatch x3 tag 7; next cycle lookup x3 with rob_value1_ready=0 -> has_dep1=1, dep1=7, get_rob_id1=7, pending_cnt=1.
- Same state, rob_value1_ready=1, rob_value1=0xDEADBEEF -> val1=0xDEADBEEF, has_dep1=0; without the macro -> has_dep1=1, dep1=7.
- Dispatch x3 tag 7, then x3 tag 9, then commit x3 tag 7 val 0x11 -> value=0x11, x3 still busy tag 9. Commit tag 9 val 0x22 -> busy=0, val=0x22, pending_cnt=0.
- Same cycle: commit x4 tag 2 (x4 busy tag 2) and dispatch x4 tag 5 -> x4 busy tag 5, value updated, pending_cnt unchanged. Same cycle: dispatch x6 with lookup of x6 (not busy, value 0x40) -> lookup returns 0x40, has_dep=0.
- Four regs busy, assert clear with commit x1 val 0x99 -> all busy=0, pending_cnt=0, x1 value unchanged. rdy_in=0 with dispatch x8 -> no change. Dispatch/commit to x0 -> x0 reads 0, not busy.
